// File: rtl/opll_bus_pkg.sv
// rtl/opll_bus_pkg.sv - shared FSM states and default bus timing for the OPLL write sequencer
package opll_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_SETUP,
        ST_ADDR_STROBE,
        ST_ADDR_WAIT,
        ST_DATA_SETUP,
        ST_DATA_STROBE,
        ST_DATA_WAIT
    } opll_state_e;

    localparam int DEF_FIFO_DEPTH       = 4;
    localparam int DEF_STROBE_CYCLES    = 4;
    localparam int DEF_ADDR_WAIT_CYCLES = 12;
    localparam int DEF_DATA_WAIT_CYCLES = 84;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/opll_wr_fifo.sv
// rtl/opll_wr_fifo.sv - power-of-two FIFO holding queued {addr, data} register writes
module opll_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push_ok, pop_ok;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset; level/pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/opll_write_sequencer.sv
// rtl/opll_write_sequencer.sv - queues OPLL register writes and plays them out with address/data bus timing
module opll_write_sequencer
    import opll_bus_pkg::*;
#(
    parameter int FIFO_DEPTH       = DEF_FIFO_DEPTH,
    parameter int STROBE_CYCLES    = DEF_STROBE_CYCLES,
    parameter int ADDR_WAIT_CYCLES = DEF_ADDR_WAIT_CYCLES,
    parameter int DATA_WAIT_CYCLES = DEF_DATA_WAIT_CYCLES
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [7:0]                  in_addr,
    input  logic [7:0]                  in_data,
    output logic [7:0]                  bus_din,
    output logic                        bus_a0,
    output logic                        bus_cs,
    output logic                        bus_wr,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int CNT_W = $clog2(max3(STROBE_CYCLES, ADDR_WAIT_CYCLES, DATA_WAIT_CYCLES) + 1);
    localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] AWAIT_LOAD  = CNT_W'(ADDR_WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWAIT_LOAD  = CNT_W'(DATA_WAIT_CYCLES - 1);

    opll_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      hold_q, hold_d;
    logic [7:0]       din_q, din_d;
    logic             a0_q, a0_d, cs_q, cs_d, wr_q, wr_d;
    logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [15:0]      fifo_rdata;

    assign in_ready  = ~reset & ~fifo_full;
    assign fifo_push = in_valid & in_ready;
    assign busy      = (state_q != ST_IDLE);
    assign bus_din   = din_q;
    assign bus_a0    = a0_q;
    assign bus_cs    = cs_q;
    assign bus_wr    = wr_q;

    opll_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (fifo_push),
        .wr_data ({in_addr, in_data}),
        .pop     (fifo_pop),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        fifo_pop = 1'b0;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            case (state_q)
                ST_IDLE: if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    hold_d   = fifo_rdata;
                    state_d  = ST_ADDR_SETUP;
                end
                ST_ADDR_SETUP:  begin state_d = ST_ADDR_STROBE; cnt_d = STROBE_LOAD; end
                ST_ADDR_STROBE: begin state_d = ST_ADDR_WAIT;   cnt_d = AWAIT_LOAD;  end
                ST_ADDR_WAIT:   begin state_d = ST_DATA_SETUP;  cnt_d = '0;          end
                ST_DATA_SETUP:  begin state_d = ST_DATA_STROBE; cnt_d = STROBE_LOAD; end
                ST_DATA_STROBE: begin state_d = ST_DATA_WAIT;   cnt_d = DWAIT_LOAD;  end
                default:        begin state_d = ST_IDLE;        cnt_d = '0;          end
            endcase
        end

        // Bus flops are decoded from the next state so they line up with state_q.
        din_d = din_q;
        a0_d  = a0_q;
        cs_d  = 1'b0;
        wr_d  = 1'b0;
        case (state_d)
            ST_ADDR_SETUP:  begin din_d = hold_d[15:8]; a0_d = 1'b0; cs_d = 1'b1; end
            ST_ADDR_STROBE: begin din_d = hold_d[15:8]; a0_d = 1'b0; cs_d = 1'b1; wr_d = 1'b1; end
            ST_DATA_SETUP:  begin din_d = hold_d[7:0];  a0_d = 1'b1; cs_d = 1'b1; end
            ST_DATA_STROBE: begin din_d = hold_d[7:0];  a0_d = 1'b1; cs_d = 1'b1; wr_d = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            din_q   <= '0;
            a0_q    <= 1'b0;
            cs_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            din_q   <= din_d;
            a0_q    <= a0_d;
            cs_q    <= cs_d;
            wr_q    <= wr_d;
        end
    end

endmodule

// File: tb/tb_opll_write_sequencer.sv
// tb/tb_opll_write_sequencer.sv - self-checking bench for opll_write_sequencer
module tb_opll_write_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid, in_ready, bus_a0, bus_cs, bus_wr, busy;
    logic [7:0] in_addr, in_data, bus_din;
    logic [2:0] fifo_level;
    logic       in_valid_m, in_ready_m, bus_a0_m, bus_cs_m, bus_wr_m, busy_m;
    logic [7:0] in_addr_m, in_data_m, bus_din_m;
    logic [2:0] fifo_level_m;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    opll_write_sequencer dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .bus_din(bus_din), .bus_a0(bus_a0),
        .bus_cs(bus_cs), .bus_wr(bus_wr), .busy(busy), .fifo_level(fifo_level)
    );

    opll_write_sequencer #(
        .FIFO_DEPTH(4), .STROBE_CYCLES(1), .ADDR_WAIT_CYCLES(1), .DATA_WAIT_CYCLES(1)
    ) dut_min (
        .clk(clk), .reset(reset), .in_valid(in_valid_m), .in_ready(in_ready_m),
        .in_addr(in_addr_m), .in_data(in_data_m), .bus_din(bus_din_m), .bus_a0(bus_a0_m),
        .bus_cs(bus_cs_m), .bus_wr(bus_wr_m), .busy(busy_m), .fifo_level(fifo_level_m)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int unsigned cyc;
        logic [7:0]  addr;
        logic [7:0]  data;
    } wr_rec_t;

    wr_rec_t     wlog[$];
    int unsigned cyc = 0;
    int unsigned n_cs_cycles = 0;
    int unsigned addr_cyc = 0;
    logic [7:0]  cur_addr = 8'h00;
    logic [7:0]  held_din = 8'h00;
    logic        held_a0 = 1'b0;
    logic        prev_wr = 1'b0;

    // Protocol monitor: WR implies CS, bus stable during each strobe, log completed writes.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus_wr) begin
                check("proto_wr_implies_cs", {31'd0, bus_cs}, 32'd1);
                if (prev_wr) begin
                    check("proto_strobe_stable", {23'd0, bus_a0, bus_din}, {23'd0, held_a0, held_din});
                end else begin
                    held_din = bus_din;
                    held_a0  = bus_a0;
                    if (!bus_a0) begin
                        cur_addr = bus_din;
                        addr_cyc = cyc;
                    end else begin
                        wlog.push_back('{addr_cyc, cur_addr, bus_din});
                    end
                end
            end
            if (bus_cs) n_cs_cycles++;
            if (bus_wr_m) check("proto_min_wr_implies_cs", {31'd0, bus_cs_m}, 32'd1);
        end
        prev_wr = bus_wr;
        cyc++;
    end

    typedef struct {
        int         off;
        logic       busy;
        logic       cs;
        logic       wr;
        logic       a0;
        logic [7:0] din;
        logic [2:0] lvl;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[12];
        int          busy_cnt;
        int          log_base;
        int unsigned cs_base;
        logic [16:1] exp_busy_m;
        logic        saw;

        vecs[0]  = '{1,   1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd1};
        vecs[1]  = '{2,   1'b1, 1'b1, 1'b0, 1'b0, 8'h10, 3'd0};
        vecs[2]  = '{3,   1'b1, 1'b1, 1'b1, 1'b0, 8'h10, 3'd0};
        vecs[3]  = '{6,   1'b1, 1'b1, 1'b1, 1'b0, 8'h10, 3'd0};
        vecs[4]  = '{7,   1'b1, 1'b0, 1'b0, 1'b0, 8'h10, 3'd0};
        vecs[5]  = '{18,  1'b1, 1'b0, 1'b0, 1'b0, 8'h10, 3'd0};
        vecs[6]  = '{19,  1'b1, 1'b1, 1'b0, 1'b1, 8'h55, 3'd0};
        vecs[7]  = '{20,  1'b1, 1'b1, 1'b1, 1'b1, 8'h55, 3'd0};
        vecs[8]  = '{23,  1'b1, 1'b1, 1'b1, 1'b1, 8'h55, 3'd0};
        vecs[9]  = '{24,  1'b1, 1'b0, 1'b0, 1'b1, 8'h55, 3'd0};
        vecs[10] = '{107, 1'b1, 1'b0, 1'b0, 1'b1, 8'h55, 3'd0};
        vecs[11] = '{108, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 3'd0};

        in_valid = 0; in_addr = 0; in_data = 0;
        in_valid_m = 0; in_addr_m = 0; in_data_m = 0;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_in_ready", {31'd0, in_ready}, 32'd0);
        check("reset_bus", {20'd0, busy, bus_cs, bus_wr, bus_a0, bus_din}, 32'd0);
        check("reset_level", {29'd0, fifo_level}, 32'd0);
        check("reset_in_ready_min", {31'd0, in_ready_m}, 32'd0);
        reset = 0;
        @(negedge clk);
        check("in_ready_after_release", {31'd0, in_ready}, 32'd1);

        // Single write, table-driven timeline
        in_valid = 1; in_addr = 8'h10; in_data = 8'h55;
        busy_cnt = 0;
        for (int n = 1; n <= 110; n++) begin
            @(negedge clk);
            if (n == 1) in_valid = 0;
            if (busy) busy_cnt++;
            for (int v = 0; v < 12; v++) begin
                if (vecs[v].off == n) begin
                    check($sformatf("single_n%0d", n),
                          {17'd0, busy, bus_cs, bus_wr, bus_a0, bus_din, fifo_level},
                          {17'd0, vecs[v].busy, vecs[v].cs, vecs[v].wr, vecs[v].a0, vecs[v].din, vecs[v].lvl});
                end
            end
        end
        check("single_busy_cycles", busy_cnt, 32'd106);
        check("single_log_count", wlog.size(), 32'd1);
        wlog.delete();

        // Queue fill while a write is in progress, then full-FIFO push on the pop cycle
        in_valid = 1; in_addr = 8'h20; in_data = 8'hAA;
        @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_addr = 8'h30 + 8'(i); in_data = 8'hC0 + 8'(i);
            check($sformatf("fill_ready_%0d", i), {31'd0, in_ready}, 32'd1);
            @(negedge clk);
        end
        in_addr = 8'h34; in_data = 8'hC4;
        check("fill_level_4", {29'd0, fifo_level}, 32'd4);
        check("fill_ready_low", {31'd0, in_ready}, 32'd0);
        saw = 0;
        for (int t = 0; t < 200 && !saw; t++) begin
            if (!busy) saw = 1;
            else @(negedge clk);
        end
        check("pop_cycle_reached", {31'd0, saw}, 32'd1);
        check("pop_cycle_level", {29'd0, fifo_level}, 32'd4);
        check("pop_cycle_refused", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check("after_pop_level", {29'd0, fifo_level}, 32'd3);
        check("after_pop_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 0;
        check("after_push_level", {29'd0, fifo_level}, 32'd4);
        for (int t = 0; t < 800 && wlog.size() < 6; t++) @(negedge clk);
        check("queue_log_count", wlog.size(), 32'd6);
        if (wlog.size() == 6) begin
            check("queue_w0", {wlog[0].addr, wlog[0].data}, 32'h20AA);
            for (int i = 1; i < 6; i++) begin
                check($sformatf("queue_w%0d", i), {wlog[i].addr, wlog[i].data},
                      {16'd0, 8'h30 + 8'(i - 1), 8'hC0 + 8'(i - 1)});
                check($sformatf("queue_spacing_%0d", i), wlog[i].cyc - wlog[i-1].cyc, 32'd107);
            end
        end
        for (int t = 0; t < 200 && busy; t++) @(negedge clk);
        check("queue_drained", {28'd0, busy, fifo_level}, 32'd0);

        // Reset asserted during the address strobe
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_addr = 8'h40 + 8'(i); in_data = 8'h11 * 8'(i + 1);
            @(negedge clk);
        end
        in_valid = 0;
        saw = 0;
        for (int t = 0; t < 20 && !saw; t++) begin
            if (bus_wr && !bus_a0) saw = 1;
            else @(negedge clk);
        end
        check("rst_strobe_reached", {31'd0, saw}, 32'd1);
        #2 reset = 1;
        #1;
        check("rst_mid_bus", {30'd0, bus_wr, bus_cs}, 32'd0);
        check("rst_mid_busy_level", {28'd0, busy, fifo_level}, 32'd0);
        check("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        reset = 0;
        cs_base  = n_cs_cycles;
        log_base = wlog.size();
        busy_cnt = 0;
        for (int t = 0; t < 250; t++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        check("rst_no_cs_after", n_cs_cycles - cs_base, 32'd0);
        check("rst_no_busy_after", busy_cnt, 32'd0);
        check("rst_no_writes_after", wlog.size() - log_base, 32'd0);

        // Minimum timing parameters: two back-to-back writes
        exp_busy_m = 16'b0011111101111110;
        in_valid_m = 1; in_addr_m = 8'h01; in_data_m = 8'h02;
        @(negedge clk);
        in_addr_m = 8'h03; in_data_m = 8'h04;
        busy_cnt = 0;
        for (int n = 1; n <= 16; n++) begin
            if (n > 1) @(negedge clk);
            if (n == 2) in_valid_m = 0;
            if (busy_m) busy_cnt++;
            check($sformatf("min_busy_n%0d", n), {31'd0, busy_m}, {31'd0, exp_busy_m[n]});
        end
        check("min_busy_total", busy_cnt, 32'd12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
